// File: rtl/seq_alu_if.sv
// Handshake/operand bundle between the EX-stage issue logic and seq_alu.
// The master side issues ops and consumes results; the slave side is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             carry;
  logic             div_zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi,
           zero, negative, overflow, carry, div_zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result_lo, result_hi,
           zero, negative, overflow, carry, div_zero, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add MULU and restoring DIVU, with a registered valid/ready result.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo, r_hi, r_a, r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_zero, r_negative, r_overflow, r_carry, r_div_zero;

  logic             w_accept;
  logic [2:0]       w_op3;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_lo, w_hi;
  logic             w_c, w_v;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_lo, w_mul_hi;
  logic [WIDTH:0]   w_rem, w_dsub;
  logic             w_dge;
  logic [WIDTH-1:0] w_div_lo, w_div_hi;

  assign bus.in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready);
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_MUL) | (r_state == S_DIV);
  assign bus.result_lo = r_lo;
  assign bus.result_hi = r_hi;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;
  assign bus.overflow  = r_overflow;
  assign bus.carry     = r_carry;
  assign bus.div_zero  = r_div_zero;

  // Any 1xxx opcode folds onto OR so the legacy 3-bit decode stays intact.
  assign w_op3  = bus.op[3] ? 3'b101 : bus.op[2:0];
  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_c  = 1'b0;
    w_v  = 1'b0;
    unique case (w_op3)
      3'b000: begin
        {w_c, w_lo} = w_sum;
        w_v = (bus.a[M] == bus.b[M]) && (w_sum[M] != bus.a[M]);
      end
      3'b001: begin
        {w_c, w_lo} = w_diff;
        w_v = (bus.a[M] != bus.b[M]) && (w_diff[M] != bus.a[M]);
      end
      3'b010: w_lo = bus.b;
      3'b011: begin
        w_lo = bus.b;
        w_hi = bus.a;
      end
      3'b100: w_lo = bus.a & bus.b;
      3'b101: w_lo = bus.a | bus.b;
      3'b111: begin
        w_lo = '1;
        w_hi = bus.a;
      end
      default: ;
    endcase
  end

  // Multiply step: {hi,lo} shifts right, multiplier bits retire out of lo[0].
  assign w_madd   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_a}) : {1'b0, r_hi};
  assign w_mul_hi = w_madd[WIDTH:1];
  assign w_mul_lo = {w_madd[0], r_lo[M:1]};

  // Divide step: remainder in hi, dividend shifts out of lo as quotient shifts in.
  assign w_rem    = {r_hi, r_lo[M]};
  assign w_dsub   = w_rem - {1'b0, r_b};
  assign w_dge    = ~w_dsub[WIDTH];
  assign w_div_hi = w_dge ? w_dsub[M:0] : w_rem[M:0];
  assign w_div_lo = {r_lo[M-1:0], w_dge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lo       <= '0;
      r_hi       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_cnt <= CW'(WIDTH - 1);
            if (w_op3 == 3'b110) begin
              r_state    <= S_MUL;
              r_hi       <= '0;
              r_lo       <= bus.b;
              r_zero     <= 1'b0;
              r_negative <= 1'b0;
              r_overflow <= 1'b0;
              r_carry    <= 1'b0;
              r_div_zero <= 1'b0;
            end else if ((w_op3 == 3'b111) && (bus.b != '0)) begin
              r_state    <= S_DIV;
              r_hi       <= '0;
              r_lo       <= bus.a;
              r_zero     <= 1'b0;
              r_negative <= 1'b0;
              r_overflow <= 1'b0;
              r_carry    <= 1'b0;
              r_div_zero <= 1'b0;
            end else begin
              r_state    <= S_DONE;
              r_lo       <= w_lo;
              r_hi       <= w_hi;
              r_zero     <= (w_lo == '0);
              r_negative <= (w_op3 != 3'b111) & w_lo[M];
              r_overflow <= w_v;
              r_carry    <= w_c;
              r_div_zero <= (w_op3 == 3'b111);
            end
          end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state    <= S_DONE;
            r_zero     <= ({w_mul_hi, w_mul_lo} == '0);
            r_overflow <= (w_mul_hi != '0);
          end
        end
        S_DIV: begin
          r_hi  <= w_div_hi;
          r_lo  <= w_div_lo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_zero  <= (w_div_lo == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for ops/flags/latency, plus
// hand sequences for reset, backpressure and reset during a multiply.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  seq_alu_if #(.WIDTH(16)) bus ();
  seq_alu #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, lo, hi;
    logic [4:0]  fl;  // {zero, negative, overflow, carry, div_zero}
    int          lat;
    int          nbusy;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [4:0] flags();
    return {bus.zero, bus.negative, bus.overflow, bus.carry, bus.div_zero};
  endfunction

  // Present one op, then scramble inputs to prove operands were captured.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int nbusy, output int nrdy);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 4'h6; bus.a = 16'hDEAD; bus.b = 16'hBEEF;
    lat = 1; nbusy = 0; nrdy = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) nbusy++;
      if (bus.in_ready) nrdy++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) nbusy++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nbusy, nrdy;
    tbl[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b01100, 1, 0};
    tbl[1]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 5'b01010, 1, 0};
    tbl[2]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 5'b10000, 1, 0};
    tbl[3]  = '{4'h3, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 5'b00000, 1, 0};
    tbl[4]  = '{4'h6, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b00100, 17, 16};
    tbl[5]  = '{4'h7, 16'd100,  16'd7,    16'd14,   16'd2,    5'b00000, 17, 16};
    tbl[6]  = '{4'h7, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 5'b00001, 1, 0};
    tbl[7]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10010, 1, 0};
    tbl[8]  = '{4'h4, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 5'b01000, 1, 0};
    tbl[9]  = '{4'h5, 16'h1234, 16'h00F0, 16'h12F4, 16'h0000, 5'b00000, 1, 0};
    tbl[10] = '{4'hA, 16'h0F00, 16'h00F0, 16'h0FF0, 16'h0000, 5'b00000, 1, 0};
    tbl[11] = '{4'h2, 16'h1111, 16'h8000, 16'h8000, 16'h0000, 5'b01000, 1, 0};
    tbl[12] = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b00100, 1, 0};
    tbl[13] = '{4'h6, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00100, 17, 16};
    tbl[14] = '{4'h6, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 5'b00000, 17, 16};
    tbl[15] = '{4'h6, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 5'b10000, 17, 16};
    tbl[16] = '{4'h7, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 5'b10000, 17, 16};
    tbl[17] = '{4'h0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 5'b10110, 1, 0};
    tbl[18] = '{4'h7, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 5'b00000, 17, 16};
    tbl[19] = '{4'hF, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 5'b00000, 1, 0};
    tbl[20] = '{4'hE, 16'h0002, 16'h0003, 16'h0003, 16'h0000, 5'b00000, 1, 0};

    bus.in_valid = 1'b0; bus.op = 4'h0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst result", {bus.result_hi, bus.result_lo}, 32'd0);
    chk("rst flags", 32'(flags()), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, nbusy, nrdy);
      chk($sformatf("v%0d lo", i), 32'(bus.result_lo), 32'(tbl[i].lo));
      chk($sformatf("v%0d hi", i), 32'(bus.result_hi), 32'(tbl[i].hi));
      chk($sformatf("v%0d flags", i), 32'(flags()), 32'(tbl[i].fl));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d busy cycles", i), 32'(nbusy), 32'(tbl[i].nbusy));
      chk($sformatf("v%0d in_ready while iterating", i), 32'(nrdy), 32'd0);
    end

    // Backpressure: result held, then retire and accept on one edge.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 16'd1; bus.b = 16'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d lo", k), 32'(bus.result_lo), 32'd3);
      chk($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 4'h4; bus.a = 16'h0F0F; bus.b = 16'h00FF;
    #1 chk("bp in_ready on retire", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp next out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp next lo", 32'(bus.result_lo), 32'h000F);
    chk("bp next flags", 32'(flags()), 32'd0);

    // Reset during the 8th multiply cycle aborts the op.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'h6; bus.a = 16'h1234; bus.b = 16'h0100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("mid-mul busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort result", {bus.result_hi, bus.result_lo}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'h0, 16'd2, 16'd2, lat, nbusy, nrdy);
    chk("post-rst lo", 32'(bus.result_lo), 32'd4);
    chk("post-rst hi", 32'(bus.result_hi), 32'd0);
    chk("post-rst flags", 32'(flags()), 32'd0);
    chk("post-rst latency", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
